// File: rtl/user_code_loader.sv
// User code loader: fills the 32-word i281 user code memory from a byte-stream
// program frame instead of relying on a hard-wired image.
//
// Frame: HDR_BYTE, N, N x {hi, lo}, CHK where CHK = XOR of N and all hi/lo bytes.
// Words 0-15 land in the low bank and 16-31 in the high bank. The address is
// simply the word index, so no bank handling is needed.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle request to begin a new load (honoured in IDLE/DONE/ERR)
//   byte_valid   byte_data carries a byte this cycle
//   byte_data    frame byte
//   byte_ready   loader accepts a byte this cycle (transfer = byte_valid & byte_ready)
//   wr_en        one-cycle code memory write strobe
//   wr_addr      code memory word address
//   wr_data      instruction word {hi, lo}
//   cpu_hold     CPU stall request while the code memory is inconsistent
//   done         level, last load succeeded
//   error        level, last load failed
//   words_loaded words written in the current/last load
module user_code_loader #(
   parameter int unsigned WORDS    = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StCnt,
      StHi,
      StLo,
      StChk,
      StDone,
      StErr
   } state_t;

   localparam logic [8:0]    WordsLim = 9'(WORDS);
   localparam logic [ADDR_W:0] One    = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [7:0]          chk_q, chk_d;
   logic [7:0]          hi_q, hi_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [15:0]         wr_data_q, wr_data_d;
   logic [ADDR_W:0]     wl_q, wl_d;
   logic                accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         chk_q     <= '0;
         hi_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wl_q      <= '0;
      end else begin
         count_q   <= count_d;
         chk_q     <= chk_d;
         hi_q      <= hi_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wl_q      <= wl_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      chk_d      = chk_q;
      hi_d       = hi_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      // The word counter advances in the cycle the write strobe is visible.
      wl_d       = wl_q + {{ADDR_W{1'b0}}, wr_en_q};

      byte_ready = (state_q == StHdr) || (state_q == StCnt) || (state_q == StHi) ||
                   (state_q == StLo)  || (state_q == StChk);
      cpu_hold   = byte_ready || (state_q == StErr);
      done       = (state_q == StDone);
      error      = (state_q == StErr);
      accept     = byte_valid && byte_ready;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StHdr;
               wl_d    = '0;
               chk_d   = '0;
            end
         end
         StHdr: begin
            // Anything other than the marker is dropped so a misaligned stream resyncs.
            if (accept && byte_data == HDR_BYTE) begin
               state_d = StCnt;
            end
         end
         StCnt: begin
            if (accept) begin
               if (byte_data == 8'h00 || {1'b0, byte_data} > WordsLim) begin
                  state_d = StErr;
               end else begin
                  count_d = byte_data[ADDR_W:0];
                  chk_d   = byte_data;
                  state_d = StHi;
               end
            end
         end
         StHi: begin
            if (accept) begin
               hi_d    = byte_data;
               chk_d   = chk_q ^ byte_data;
               state_d = StLo;
            end
         end
         StLo: begin
            if (accept) begin
               chk_d     = chk_q ^ byte_data;
               wr_en_d   = 1'b1;
               wr_addr_d = wl_q[ADDR_W-1:0];
               wr_data_d = {hi_q, byte_data};
               state_d   = ((wl_q + One) == count_q) ? StChk : StHi;
            end
         end
         StChk: begin
            if (accept) begin
               state_d = (byte_data == chk_q) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign words_loaded = wl_q;

endmodule
